gray_seq_ctrl: RTL

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gray_seq_ctrl.sv
// ----------------------------------------------------------------------------
// gray_seq_ctrl
//
// Purpose:
//   Generates a binary count sequence and its Gray-code image under a
//   valid/ready handshake. A sequence is armed from IDLE by start, counts up
//   from 0 to a captured limit or down from the limit to 0, and then
//   announces completion with a one-cycle done pulse. stop aborts a running
//   sequence without a done pulse.
//
// Optional feature:
//   GRAY_SEQ_CHECK_EN - when defined, an adjacency checker is compiled in.
//   It sets the sticky err flag if any stepping transfer changes the Gray
//   code in other than exactly one bit. When undefined, err is tied to 0.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a sequence (sampled in IDLE only)
//   stop       in   1      abort a sequence (sampled in RUN); wins over start
//   dir        in   1      0 = count up, 1 = count down (captured at start)
//   limit      in   WIDTH  terminal binary value (captured at start)
//   out_ready  in   1      downstream accepts the current code
//   binary     out  WIDTH  current binary count (registered)
//   gray       out  WIDTH  Gray code of binary (registered)
//   out_valid  out  1      binary/gray hold a code to be consumed (RUN)
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle completion pulse
//   err        out  1      sticky Gray adjacency error
// ----------------------------------------------------------------------------
module gray_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;

    logic             r_dir;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_binary;
    logic [WIDTH-1:0] r_gray;

    logic             w_start_ok;
    logic             w_xfer;
    logic             w_at_terminal;
    logic             w_step;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    assign w_start_ok    = (r_state == IDLE) && start && !stop;
    assign w_xfer        = (r_state == RUN) && out_ready;
    // Terminal value is the limit when counting up and 0 when counting down.
    // Checking it before stepping keeps a legal sequence from ever wrapping.
    assign w_at_terminal = (r_binary == (r_dir ? '0 : r_limit));
    // A transfer that happens together with stop still consumes the code, so
    // the count steps; only the state machine is aborted.
    assign w_step        = w_xfer && !w_at_terminal;
    assign w_bin_step    = r_dir ? (r_binary - ONE) : (r_binary + ONE);

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first so that no path leaves it unassigned (no latch).
        w_bin_next = r_binary;
        if (w_start_ok) begin
            w_bin_next = dir ? limit : '0;
        end else if (w_step) begin
            w_bin_next = w_bin_step;
        end
    end

    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_next = IDLE;
                end else if (w_xfer && w_at_terminal) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            IDLE: ;
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: captured configuration and code registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir    <= 1'b0;
            r_limit  <= '0;
            r_binary <= '0;
            r_gray   <= '0;
        end else begin
            if (w_start_ok) begin
                r_dir   <= dir;
                r_limit <= limit;
            end
            r_binary <= w_bin_next;
            r_gray   <= w_gray_next;
        end
    end

    assign binary = r_binary;
    assign gray   = r_gray;

    // ------------------------------------------------------------------------
    // Optional Gray adjacency checker
    // ------------------------------------------------------------------------
`ifdef GRAY_SEQ_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_step && !$onehot(w_gray_next ^ r_gray)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
